// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int unsigned AW_DEF = 6;

  localparam logic [3:0] WE_NONE  = 4'b0000;
  localparam logic [3:0] WE_BYTE0 = 4'b0001;
  localparam logic [3:0] WE_WORD  = 4'b1111;

  typedef enum logic {
    S_CPRI = 1'b0,
    S_XPRI = 1'b1
  } arb_state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester (core C, external X) and DMem bus signals; slave = arbiter side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
);
  logic          c_req;
  logic [3:0]    c_we;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata;
  logic          c_gnt;
  logic          c_stall;
  logic          c_rvalid;
  logic [31:0]   c_rdata;

  logic          x_req;
  logic [3:0]    x_we;
  logic [AW-1:0] x_addr;
  logic [31:0]   x_wdata;
  logic          x_gnt;
  logic          x_rvalid;
  logic [31:0]   x_rdata;

  logic [AW-1:0] m_addr;
  logic [3:0]    m_we;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    input  x_req, x_we, x_addr, x_wdata,
    output x_gnt, x_rvalid, x_rdata,
    output m_addr, m_we, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    output x_req, x_we, x_addr, x_wdata,
    input  x_gnt, x_rvalid, x_rdata,
    input  m_addr, m_we, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arb_rport.sv
// Per-requester read return: pending flag, rvalid pulse and rdata hold register.
module dmem_arb_rport (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rd_start,
  input  logic [31:0] m_rdata,
  output logic        rvalid,
  output logic [31:0] rdata
);
  logic        pend;
  logic [31:0] cap;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend <= 1'b0;
      cap  <= '0;
    end else begin
      pend <= rd_start;
      if (pend) cap <= m_rdata;
    end
  end

  // Live memory data in the return cycle, held copy afterwards.
  always_comb begin
    rvalid = pend;
    rdata  = pend ? m_rdata : cap;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority DMem arbiter with starvation escape for the external port.
// Optional conflict counter output enabled by `define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              nrst,
  dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);
  if (DW != 32) begin : g_dw_check
    $error("dmem_arbiter: DW must be 32");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_mw_check
    $error("dmem_arbiter: MAX_WAIT must be 1..15");
  end

  localparam logic [3:0] MW = 4'(MAX_WAIT);

  arb_state_e    state, state_nxt;
  logic [3:0]    wait_cnt, wait_nxt;
  logic          c_gnt, x_gnt, x_denied;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  // Grants are gated by nrst so every output reads 0 while in reset.
  always_comb begin
    c_gnt = 1'b0;
    x_gnt = 1'b0;
    if (nrst) begin
      if (state == S_XPRI) begin
        x_gnt = bus.x_req;
        c_gnt = bus.c_req & ~bus.x_req;
      end else begin
        c_gnt = bus.c_req;
        x_gnt = bus.x_req & ~bus.c_req;
      end
    end
  end

  always_comb begin
    x_denied  = bus.x_req & ~x_gnt;
    state_nxt = state;
    wait_nxt  = '0;
    if (x_denied) wait_nxt = (wait_cnt >= MW) ? MW : wait_cnt + 4'd1;
    unique case (state)
      S_CPRI: if (x_denied && wait_cnt == MW - 4'd1) state_nxt = S_XPRI;
      S_XPRI: if (x_gnt || !bus.x_req) state_nxt = S_CPRI;
      default: state_nxt = S_CPRI;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_CPRI;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (c_gnt || x_gnt) begin
        addr_q  <= bus.m_addr;
        wdata_q <= bus.m_wdata;
      end
    end
  end

  always_comb begin
    bus.m_we    = WE_NONE;
    bus.m_addr  = addr_q;
    bus.m_wdata = wdata_q;
    if (c_gnt) begin
      bus.m_we    = bus.c_we;
      bus.m_addr  = bus.c_addr;
      bus.m_wdata = bus.c_wdata;
    end else if (x_gnt) begin
      bus.m_we    = bus.x_we;
      bus.m_addr  = bus.x_addr;
      bus.m_wdata = bus.x_wdata;
    end
    bus.c_gnt   = c_gnt;
    bus.x_gnt   = x_gnt;
    bus.c_stall = nrst & bus.c_req & ~c_gnt;
  end

  dmem_arb_rport u_rport_c (
    .clk      (clk),
    .nrst     (nrst),
    .rd_start (c_gnt && (bus.c_we == WE_NONE)),
    .m_rdata  (bus.m_rdata),
    .rvalid   (bus.c_rvalid),
    .rdata    (bus.c_rdata)
  );

  dmem_arb_rport u_rport_x (
    .clk      (clk),
    .nrst     (nrst),
    .rd_start (x_gnt && (bus.x_we == WE_NONE)),
    .m_rdata  (bus.m_rdata),
    .rvalid   (bus.x_rvalid),
    .rdata    (bus.x_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) conflict_cnt <= '0;
    else if (bus.c_req && bus.x_req && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed literal checks plus randomized traffic vs a reference model.
module tb_dmem_arbiter;
  localparam int unsigned AW       = 6;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned NW       = 1 << AW;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW)) bus ();
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  dmem_arbiter #(.AW(AW), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Memory environment: 1-cycle registered read, byte-lane writes.
  logic [31:0] mem [NW];
  always @(posedge clk) begin
    bus.m_rdata <= mem[bus.m_addr];
    for (int unsigned b = 0; b < 4; b++)
      if (bus.m_we[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
  end

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: X wins once it has been refused MAX_WAIT cycles in a row.
  logic [31:0]   ref_mem [NW];
  int            denials;
  bit            pc, px;
  logic [31:0]   pcd, pxd, c_last, x_last;
  logic [AW-1:0] last_addr;
  int            conflicts;
  bit            eg_c, eg_x;

  function automatic void model_reset();
    denials = 0; pc = 0; px = 0; pcd = '0; pxd = '0;
    c_last = '0; x_last = '0; last_addr = '0; conflicts = 0;
  endfunction

  function automatic void model_check();
    eg_c = 0; eg_x = 0;
    if (!nrst) begin
      model_reset();
      chk("rst_c_gnt", 32'(bus.c_gnt), 0);
      chk("rst_x_gnt", 32'(bus.x_gnt), 0);
      chk("rst_c_stall", 32'(bus.c_stall), 0);
      chk("rst_m_we", 32'(bus.m_we), 0);
      chk("rst_m_addr", 32'(bus.m_addr), 0);
      chk("rst_m_wdata", bus.m_wdata, 0);
      chk("rst_c_rvalid", 32'(bus.c_rvalid), 0);
      chk("rst_x_rvalid", 32'(bus.x_rvalid), 0);
      chk("rst_c_rdata", bus.c_rdata, 0);
      chk("rst_x_rdata", bus.x_rdata, 0);
    end else begin
      eg_x = bus.x_req && (denials >= int'(MAX_WAIT) || !bus.c_req);
      eg_c = bus.c_req && !eg_x;
      chk("c_gnt", 32'(bus.c_gnt), 32'(eg_c));
      chk("x_gnt", 32'(bus.x_gnt), 32'(eg_x));
      chk("c_stall", 32'(bus.c_stall), 32'(bus.c_req && !eg_c));
      chk("m_we", 32'(bus.m_we), eg_c ? 32'(bus.c_we) : eg_x ? 32'(bus.x_we) : 0);
      chk("m_addr", 32'(bus.m_addr),
          eg_c ? 32'(bus.c_addr) : eg_x ? 32'(bus.x_addr) : 32'(last_addr));
      if (eg_c || eg_x)
        chk("m_wdata", bus.m_wdata, eg_c ? bus.c_wdata : bus.x_wdata);
      chk("c_rvalid", 32'(bus.c_rvalid), 32'(pc));
      chk("x_rvalid", 32'(bus.x_rvalid), 32'(px));
      chk("c_rdata", bus.c_rdata, pc ? pcd : c_last);
      chk("x_rdata", bus.x_rdata, px ? pxd : x_last);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(conflicts));
`endif
  endfunction

  function automatic void model_update();
    logic [3:0] we;
    logic [AW-1:0] a;
    logic [31:0] d;
    if (!nrst) begin
      model_reset();
      return;
    end
    if (pc) c_last = pcd;
    if (px) x_last = pxd;
    pc = eg_c && bus.c_we == 4'b0;
    px = eg_x && bus.x_we == 4'b0;
    if (eg_c || eg_x) begin
      we = eg_c ? bus.c_we : bus.x_we;
      a  = eg_c ? bus.c_addr : bus.x_addr;
      d  = eg_c ? bus.c_wdata : bus.x_wdata;
      last_addr = a;
      if (eg_c && pc) pcd = ref_mem[a];
      if (eg_x && px) pxd = ref_mem[a];
      for (int unsigned b = 0; b < 4; b++)
        if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    if (bus.x_req && !eg_x) denials = (denials < int'(MAX_WAIT)) ? denials + 1 : denials;
    else denials = 0;
    if (bus.c_req && bus.x_req && conflicts < 65535) conflicts++;
  endfunction

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_c(bit req, logic [3:0] we, int addr, logic [31:0] wd);
    bus.c_req = req; bus.c_we = we; bus.c_addr = AW'(addr); bus.c_wdata = wd;
  endtask

  task automatic set_x(bit req, logic [3:0] we, int addr, logic [31:0] wd);
    bus.x_req = req; bus.x_we = we; bus.x_addr = AW'(addr); bus.x_wdata = wd;
  endtask

  initial begin
    bit c_pend, x_pend;
    for (int unsigned i = 0; i < NW; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    mem[9] = 32'h11223344;
    for (int unsigned i = 0; i < NW; i++) ref_mem[i] = mem[i];
    model_reset();

    // Reset with both requests high: everything must read 0.
    nrst = 1'b0;
    set_c(1, 4'hF, 7, 32'hFFFF_FFFF);
    set_x(1, 4'hF, 8, 32'hFFFF_FFFF);
    @(negedge clk);
    settle();
    chk("reset_c_gnt", 32'(bus.c_gnt), 0);
    chk("reset_m_we", 32'(bus.m_we), 0);
    tick(); tick();
    set_c(0, 4'h0, 0, 0); set_x(0, 4'h0, 0, 0);
    nrst = 1'b1;
    settle(); tick();

    // Core read of word 5.
    set_c(1, 4'h0, 5, 0);
    settle();
    chk("rd5_c_gnt", 32'(bus.c_gnt), 1);
    chk("rd5_m_addr", 32'(bus.m_addr), 5);
    tick();
    set_c(0, 4'h0, 0, 0);
    settle();
    chk("rd5_c_rvalid", 32'(bus.c_rvalid), 1);
    chk("rd5_c_rdata", bus.c_rdata, 32'hDEADBEEF);
    chk("rd5_x_rvalid", 32'(bus.x_rvalid), 0);
    tick();
    settle();
    chk("rd5_rvalid_pulse", 32'(bus.c_rvalid), 0);
    chk("rd5_rdata_hold", bus.c_rdata, 32'hDEADBEEF);
    tick();

    // Core word write vs external read of the same word.
    set_c(1, 4'hF, 3, 32'h12345678);
    set_x(1, 4'h0, 3, 0);
    settle();
    chk("sw3_c_gnt", 32'(bus.c_gnt), 1);
    chk("sw3_x_gnt", 32'(bus.x_gnt), 0);
    chk("sw3_m_we", 32'(bus.m_we), 32'hF);
    tick();
    set_c(0, 4'h0, 0, 0);
    settle();
    chk("sw3_x_gnt_next", 32'(bus.x_gnt), 1);
    tick();
    set_x(0, 4'h0, 0, 0);
    settle();
    chk("sw3_x_rvalid", 32'(bus.x_rvalid), 1);
    chk("sw3_x_rdata", bus.x_rdata, 32'h12345678);
    tick();

    // Starvation: both held high.
    set_c(1, 4'h0, 7, 0);
    set_x(1, 4'h0, 1, 0);
    for (int unsigned i = 0; i < MAX_WAIT; i++) begin
      settle();
      chk("starve_x_denied", 32'(bus.x_gnt), 0);
      tick();
    end
    settle();
    chk("starve_x_forced", 32'(bus.x_gnt), 1);
    chk("starve_c_stall", 32'(bus.c_stall), 1);
    tick();
    settle();
    chk("starve_c_back", 32'(bus.c_gnt), 1);
    chk("starve_x_again", 32'(bus.x_gnt), 0);
    tick();
    for (int unsigned i = 1; i < MAX_WAIT; i++) begin
      settle();
      chk("starve_cnt_cleared", 32'(bus.x_gnt), 0);
      tick();
    end
    set_c(0, 4'h0, 0, 0); set_x(0, 4'h0, 0, 0);
    settle(); tick();

    // Byte write into word 9, then read it back.
    set_c(1, 4'h1, 9, 32'h000000AA);
    settle();
    chk("sb9_m_we", 32'(bus.m_we), 32'h1);
    tick();
    set_c(1, 4'h0, 9, 0);
    settle(); tick();
    set_c(0, 4'h0, 0, 0);
    settle();
    chk("sb9_rdata", bus.c_rdata, 32'h112233AA);
    tick();

    // Reset right after an external read grant.
    set_x(1, 4'h0, 2, 0);
    settle();
    chk("rstmid_x_gnt", 32'(bus.x_gnt), 1);
    tick();
    set_x(0, 4'h0, 0, 0);
    nrst = 1'b0;
    settle();
    chk("rstmid_x_rvalid", 32'(bus.x_rvalid), 0);
    tick(); tick();
    nrst = 1'b1;
    settle();
    chk("rstmid_no_rvalid", 32'(bus.x_rvalid), 0);
    tick();
    set_c(1, 4'h0, 4, 0); set_x(1, 4'h0, 4, 0);
    settle();
    chk("rstmid_cpri", 32'(bus.c_gnt), 1);
    tick();
    set_c(0, 4'h0, 0, 0); set_x(0, 4'h0, 0, 0);
    settle(); tick();

`ifdef DMEM_ARB_STATS_EN
    nrst = 1'b0; settle(); tick();
    nrst = 1'b1;
    set_c(1, 4'h0, 1, 0); set_x(1, 4'h0, 2, 0);
    for (int unsigned i = 0; i < 10; i++) begin settle(); tick(); end
    set_c(0, 4'h0, 0, 0); set_x(0, 4'h0, 0, 0);
    settle();
    chk("stats_ten", 32'(conflict_cnt), 10);
    tick();
`endif

    // Randomized traffic; requesters hold fields until granted.
    c_pend = 0; x_pend = 0;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        nrst = 1'b0;
        c_pend = 0; x_pend = 0;
        set_c(0, 4'h0, 0, 0); set_x(0, 4'h0, 0, 0);
        settle(); tick();
        nrst = 1'b1;
      end
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1;
        set_c(1, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
              int'($urandom_range(0, NW - 1)), $urandom);
      end else if (!c_pend) begin
        set_c(0, 4'h0, 0, 0);
      end
      if (!x_pend && $urandom_range(0, 2) != 0) begin
        x_pend = 1;
        set_x(1, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
              int'($urandom_range(0, NW - 1)), $urandom);
      end else if (!x_pend) begin
        set_x(0, 4'h0, 0, 0);
      end
      settle();
      tick();
      if (eg_c) begin c_pend = 0; bus.c_req = 0; end
      if (eg_x) begin x_pend = 0; bus.x_req = 0; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
